// File: rtl/pc_fetch_unit_pkg.sv
// Shared constants and FSM state type for the PC/fetch unit.
package pc_fetch_unit_pkg;

    localparam int unsigned JUMP_IDX_W = 26;
    localparam int unsigned PC_INCR    = 4;
    localparam int unsigned INSTR_W    = 32;
    localparam int unsigned CNT_W      = 32;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_EXEC  = 2'd1,
        ST_ERR   = 2'd2
    } state_e;

    // A register-indirect target must land on a word boundary.
    function automatic logic is_misaligned(input logic [1:0] lsb);
        return lsb != 2'b00;
    endfunction

endpackage

// File: rtl/next_pc_sel.sv
// Combinational redirect-target compute and jr > jump > taken-branch > pc+4 select.
module next_pc_sel
    import pc_fetch_unit_pkg::*;
#(
    parameter int unsigned ADDR_W = 32
) (
    input  logic [ADDR_W-1:0]     pc_plus4,
    input  logic                  branch,
    input  logic                  zero,
    input  logic [ADDR_W-1:0]     branch_offset,
    input  logic                  jump,
    input  logic [JUMP_IDX_W-1:0] jump_index,
    input  logic                  jr,
    input  logic [ADDR_W-1:0]     jr_target,
    output logic [ADDR_W-1:0]     next_pc_c,
    output logic                  misaligned_c
);

    localparam int unsigned JT_W = JUMP_IDX_W + 2;

    logic [ADDR_W-1:0] branch_tgt;
    logic [ADDR_W-1:0] jump_tgt;
    logic [JT_W-1:0]   jump_low;

    assign branch_tgt = pc_plus4 + (branch_offset << 2);
    assign jump_low   = {jump_index, 2'b00};

    // Full-width PCs keep the current 256 MiB region; narrower PCs just truncate.
    if (ADDR_W == 32) begin : g_jump_region
        assign jump_tgt = {pc_plus4[ADDR_W-1:JT_W], jump_low};
    end else begin : g_jump_trunc
        assign jump_tgt = ADDR_W'(jump_low);
    end

    always_comb begin
        next_pc_c = pc_plus4;
        if (jr) begin
            next_pc_c = jr_target;
        end else if (jump) begin
            next_pc_c = jump_tgt;
        end else if (branch && zero) begin
            next_pc_c = branch_tgt;
        end
    end

    assign misaligned_c = jr && is_misaligned(jr_target[1:0]);

endmodule

// File: rtl/pc_fetch_unit.sv
// Single-issue PC and instruction-fetch unit: FETCH/EXEC/ERR sequencing,
// instruction register and retired-instruction counter.
module pc_fetch_unit
    import pc_fetch_unit_pkg::*;
#(
    parameter int unsigned ADDR_W    = 32,
    parameter logic [31:0] RESET_VEC = 32'h0000_0000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  stall,
    input  logic                  branch,
    input  logic                  zero,
    input  logic [ADDR_W-1:0]     branch_offset,
    input  logic                  jump,
    input  logic [JUMP_IDX_W-1:0] jump_index,
    input  logic                  jr,
    input  logic [ADDR_W-1:0]     jr_target,
    output logic                  imem_req,
    output logic [ADDR_W-1:0]     imem_addr,
    input  logic                  imem_ack,
    input  logic [INSTR_W-1:0]    imem_rdata,
    output logic                  instr_valid,
    output logic [INSTR_W-1:0]    instr,
    output logic [ADDR_W-1:0]     pc_out,
    output logic [ADDR_W-1:0]     pc_plus4,
    output logic                  fetch_err,
    output logic [CNT_W-1:0]      instret
);

    localparam logic [ADDR_W-1:0] RST_PC = ADDR_W'(RESET_VEC);

    state_e             state_q, state_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic [CNT_W-1:0]   instret_q, instret_d;
    logic               err_q, err_d;

    logic [ADDR_W-1:0]  pc_plus4_c;
    logic [ADDR_W-1:0]  next_pc_c;
    logic               misaligned_c;

    assign pc_plus4_c = pc_q + ADDR_W'(PC_INCR);

    next_pc_sel #(
        .ADDR_W (ADDR_W)
    ) u_next_pc_sel (
        .pc_plus4      (pc_plus4_c),
        .branch        (branch),
        .zero          (zero),
        .branch_offset (branch_offset),
        .jump          (jump),
        .jump_index    (jump_index),
        .jr            (jr),
        .jr_target     (jr_target),
        .next_pc_c     (next_pc_c),
        .misaligned_c  (misaligned_c)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_FETCH;
            pc_q      <= RST_PC;
            instr_q   <= '0;
            instret_q <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            instr_q   <= instr_d;
            instret_q <= instret_d;
            err_q     <= err_d;
        end
    end

    // Redirect inputs only matter on the EXEC cycle that actually retires.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        instr_d   = instr_q;
        instret_d = instret_q;
        err_d     = err_q;
        unique case (state_q)
            ST_FETCH: begin
                if (imem_ack) begin
                    instr_d = imem_rdata;
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (!stall) begin
                    if (misaligned_c) begin
                        err_d   = 1'b1;
                        state_d = ST_ERR;
                    end else begin
                        pc_d      = next_pc_c;
                        instret_d = instret_q + CNT_W'(1);
                        state_d   = ST_FETCH;
                    end
                end
            end
            ST_ERR: begin
                state_d = ST_ERR;
            end
            default: begin
                state_d = ST_FETCH;
            end
        endcase
    end

    // Request is gated by reset so an in-flight fetch drops immediately.
    assign imem_req    = (state_q == ST_FETCH) && !reset;
    assign imem_addr   = pc_q;
    assign instr_valid = (state_q == ST_EXEC);
    assign instr       = instr_q;
    assign pc_out      = pc_q;
    assign pc_plus4    = pc_plus4_c;
    assign fetch_err   = err_q;
    assign instret     = instret_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed and randomized bench for pc_fetch_unit against a cycle-level
// reference model of the fetch/execute behaviour.
module tb_pc_fetch_unit;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        branch;
    logic        zero;
    logic [31:0] branch_offset;
    logic        jump;
    logic [25:0] jump_index;
    logic        jr;
    logic [31:0] jr_target;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] pc_out;
    logic [31:0] pc_plus4;
    logic        fetch_err;
    logic [31:0] instret;

    int tests_run = 0;
    int tests_failed = 0;

    // Reference model state
    logic [31:0] m_pc;
    logic [31:0] m_instr;
    logic [31:0] m_instret;
    bit          m_exec;
    bit          m_err;
    bit          m_rst;

    pc_fetch_unit #(
        .ADDR_W    (32),
        .RESET_VEC (32'h0000_0000)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .stall         (stall),
        .branch        (branch),
        .zero          (zero),
        .branch_offset (branch_offset),
        .jump          (jump),
        .jump_index    (jump_index),
        .jr            (jr),
        .jr_target     (jr_target),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ack      (imem_ack),
        .imem_rdata    (imem_rdata),
        .instr_valid   (instr_valid),
        .instr         (instr),
        .pc_out        (pc_out),
        .pc_plus4      (pc_plus4),
        .fetch_err     (fetch_err),
        .instret       (instret)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog tests=%0d", tests_run);
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic full_chk();
        chk("imem_req",    32'(imem_req),    32'(!m_rst && !m_exec && !m_err));
        chk("imem_addr",   imem_addr,        m_pc);
        chk("instr_valid", 32'(instr_valid), 32'(m_exec));
        chk("instr",       instr,            m_instr);
        chk("pc_out",      pc_out,           m_pc);
        chk("pc_plus4",    pc_plus4,         m_pc + 32'd4);
        chk("fetch_err",   32'(fetch_err),   32'(m_err));
        chk("instret",     instret,          m_instret);
    endtask

    function automatic logic [31:0] model_next();
        logic [31:0] seq;
        seq = m_pc + 32'd4;
        if (jr)                 return jr_target;
        if (jump)               return (seq & 32'hF000_0000) | (32'(jump_index) * 32'd4);
        if (branch && zero)     return seq + branch_offset * 32'd4;
        return seq;
    endfunction

    // Advance one clock, step the model with the inputs that were live at the edge.
    task automatic tick();
        logic [31:0] np;
        np = model_next();
        @(posedge clk);
        #1;
        if (!m_rst && !m_err) begin
            if (!m_exec) begin
                if (imem_ack) begin
                    m_instr = imem_rdata;
                    m_exec  = 1'b1;
                end
            end else if (!stall) begin
                if (jr && (jr_target % 4 != 0)) begin
                    m_err  = 1'b1;
                    m_exec = 1'b0;
                end else begin
                    m_pc      = np;
                    m_instret = m_instret + 32'd1;
                    m_exec    = 1'b0;
                end
            end
        end
        full_chk();
    endtask

    task automatic clear_redirects();
        branch = 0; zero = 0; branch_offset = 0;
        jump = 0; jump_index = 0; jr = 0; jr_target = 0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        m_rst = 1'b1; m_pc = 32'h0; m_instr = 32'h0; m_instret = 32'h0;
        m_exec = 1'b0; m_err = 1'b0;
        #1;
        full_chk();
        repeat (2) @(posedge clk);
        #1;
        full_chk();
        imem_ack = 1'b0;
        reset = 1'b0;
        m_rst = 1'b0;
        #1;
        full_chk();
        chk("rst_req", 32'(imem_req), 32'd1);
        chk("rst_addr", imem_addr, 32'h0);
    endtask

    initial begin
        reset = 1'b1; stall = 0; imem_ack = 0; imem_rdata = 0;
        clear_redirects();
        #1;
        do_reset();

        // Sequential fetch with zero-wait memory: two cycles per instruction.
        imem_ack = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("seq_addr", imem_addr, 32'(i * 4));
            imem_rdata = $urandom;
            tick();
            tick();
        end
        chk("instret_after_8", instret, 32'd4);

        // Taken branch backwards by two words, then not-taken.
        tick();
        branch = 1; zero = 1; branch_offset = 32'hFFFF_FFFE;
        tick();
        chk("branch_taken", imem_addr, 32'h0000_000C);
        clear_redirects();
        tick(); tick(); tick();
        branch = 1; zero = 0; branch_offset = 32'hFFFF_FFFE;
        tick();
        chk("branch_not_taken", imem_addr, 32'h0000_0014);
        clear_redirects();

        // Jump stays in the current region; jr beats jump.
        tick();
        jr = 1; jr_target = 32'h4000_0000;
        tick();
        clear_redirects();
        chk("jr_to_region", imem_addr, 32'h4000_0000);
        tick();
        jump = 1; jump_index = 26'h100;
        tick();
        chk("jump_target", imem_addr, 32'h4000_0400);
        clear_redirects();
        tick();
        jr = 1; jump = 1; jump_index = 26'h3FF_FFFF; jr_target = 32'h80;
        tick();
        chk("jr_priority", imem_addr, 32'h0000_0080);
        clear_redirects();

        // Slow memory with stall asserted during FETCH and EXEC.
        imem_ack = 0; stall = 1;
        repeat (3) begin
            tick();
            chk("slow_addr_stable", imem_addr, 32'h80);
        end
        imem_ack = 1; imem_rdata = 32'h1234_5678;
        tick();
        chk("slow_capture", instr, 32'h1234_5678);
        imem_ack = 0; imem_rdata = 32'hFFFF_0000;
        repeat (3) begin
            jr = 1; jr_target = 32'h0000_0003;
            tick();
            chk("stall_instr_hold", instr, 32'h1234_5678);
            chk("stall_valid_hold", 32'(instr_valid), 32'd1);
        end
        clear_redirects();
        stall = 0;
        tick();
        chk("stall_release_pc", pc_out, 32'h84);

        // Misaligned jr locks into the error state until reset.
        imem_ack = 1;
        tick();
        jr = 1; jr_target = 32'h82;
        tick();
        chk("err_flag", 32'(fetch_err), 32'd1);
        chk("err_pc_hold", pc_out, 32'h84);
        clear_redirects();
        repeat (3) begin
            tick();
            chk("err_no_req", 32'(imem_req), 32'd0);
        end
        do_reset();
        chk("err_cleared", 32'(fetch_err), 32'd0);

        // Counter wraps from all-ones.
        imem_ack = 1;
        tick();
        stall = 1;
        force dut.instret_q = 32'hFFFF_FFFF;
        #1;
        release dut.instret_q;
        m_instret = 32'hFFFF_FFFF;
        tick();
        stall = 0;
        tick();
        chk("instret_wrap", instret, 32'h0);

        // Reset mid-fetch while memory is answering: response must not land.
        imem_ack = 0;
        tick();
        imem_ack = 1; imem_rdata = 32'hDEAD_BEEF;
        do_reset();
        tick();
        chk("late_ack_ignored", instr, 32'h0);

        // Randomized traffic; redirects toggle every cycle to exercise sampling rules.
        for (int n = 0; n < 400; n++) begin
            imem_ack      = ($urandom_range(0, 1) == 1);
            imem_rdata    = $urandom;
            stall         = ($urandom_range(0, 3) == 0);
            branch        = ($urandom_range(0, 9) < 3);
            zero          = ($urandom_range(0, 1) == 1);
            branch_offset = 32'($urandom_range(0, 63));
            branch_offset = branch_offset - 32'd32;
            jump          = ($urandom_range(0, 19) < 3);
            jump_index    = 26'($urandom);
            jr            = ($urandom_range(0, 9) == 0);
            jr_target     = $urandom & 32'hFFFF_FFFC;
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
